// File: rtl/pooling_pkg.sv
package pooling_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    OUT    = 2'd3
  } state_t;

  typedef enum logic {
    POOL_MEAN = 1'b0,
    POOL_MAX  = 1'b1
  } mode_t;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int acc_width(input int il, input int fl, input int max_len);
    return il + fl + len_width(max_len);
  endfunction

endpackage

// File: rtl/pool_divider.sv
module pool_divider #(
  parameter int ACC_W = 25,
  parameter int LEN_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] dividend,
  input  logic [LEN_W-1:0]        divisor,
  output logic                    done,
  output logic signed [ACC_W-1:0] quotient
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] q_q, q_src, q_d;
  logic [LEN_W-1:0] rem_q, rem_src, rem_d;
  logic [LEN_W-1:0] dvs_q, dvs_src;
  logic [LEN_W:0]   trial;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;

  // The start cycle already performs the first iteration on the freshly
  // loaded magnitude, so the result is ready ACC_W edges after start.
  always_comb begin
    q_src   = start ? (dividend[ACC_W-1] ? (~dividend + ACC_W'(1)) : dividend) : q_q;
    rem_src = start ? '0 : rem_q;
    dvs_src = start ? divisor : dvs_q;
    trial   = {rem_src, q_src[ACC_W-1]} - {1'b0, dvs_src};
    if (!trial[LEN_W]) begin
      rem_d = trial[LEN_W-1:0];
      q_d   = {q_src[ACC_W-2:0], 1'b1};
    end else begin
      rem_d = {rem_src[LEN_W-2:0], q_src[ACC_W-1]};
      q_d   = {q_src[ACC_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      q_q   <= q_d;
      rem_q <= rem_d;
      dvs_q <= divisor;
      neg_q <= dividend[ACC_W-1];
      cnt_q <= CNT_W'(ACC_W - 1);
      done  <= 1'b0;
    end else if (cnt_q != '0) begin
      q_q   <= q_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CNT_W'(1);
      done  <= (cnt_q == CNT_W'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign quotient = neg_q ? (~q_q + ACC_W'(1)) : q_q;

endmodule

// File: rtl/pooling_unit.sv
module pooling_unit
  import pooling_pkg::*;
#(
  parameter  int IL       = 4,
  parameter  int FL       = 16,
  parameter  int CHANNELS = 4,
  parameter  int MAX_LEN  = 16,
  localparam int LEN_W    = len_width(MAX_LEN),
  localparam int ACC_W    = acc_width(IL, FL, MAX_LEN),
  localparam int DW       = IL + FL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [LEN_W-1:0]     len_cfg,
  input  logic signed [DW-1:0] in_data [CHANNELS],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_data [CHANNELS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                  state_q, state_d;
  mode_t                   mode_q;
  logic [LEN_W-1:0]        len_q, cnt_q, len_clamped;
  logic signed [ACC_W-1:0] acc_q [CHANNELS];
  logic signed [ACC_W-1:0] acc_d [CHANNELS];
  logic signed [ACC_W-1:0] ext   [CHANNELS];
  logic signed [ACC_W-1:0] quot  [CHANNELS];
  logic [CHANNELS-1:0]     div_done;
  logic                    start_ok, beat, last_beat, div_start;

  always_comb begin
    len_clamped = (len_cfg > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_cfg;
    start_ok    = start && (state_q == IDLE);
    beat        = in_valid && (state_q == ACCUM);
    last_beat   = beat && (cnt_q == len_q - LEN_W'(1));
    div_start   = last_beat && (mode_q == POOL_MEAN);
  end

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ext[c]   = {{(ACC_W-DW){in_data[c][DW-1]}}, in_data[c]};
      acc_d[c] = acc_q[c];
      if (beat) begin
        if (mode_q == POOL_MEAN) acc_d[c] = acc_q[c] + ext[c];
        else if (ext[c] > acc_q[c]) acc_d[c] = ext[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_clamped == '0) ? OUT : ACCUM;
      ACCUM:   if (last_beat) state_d = (mode_q == POOL_MEAN) ? DIVIDE : OUT;
      DIVIDE:  if (&div_done) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= POOL_MEAN;
      len_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        acc_q[c]    <= '0;
        out_data[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q <= mode_t'(mode);
        len_q  <= len_clamped;
        cnt_q  <= '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          acc_q[c] <= (mode_t'(mode) == POOL_MAX) ? ACC_MIN : '0;
          if (len_clamped == '0) out_data[c] <= '0;
        end
      end else if (beat) begin
        cnt_q <= cnt_q + LEN_W'(1);
        for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
      end
      if (last_beat && mode_q == POOL_MAX) begin
        for (int unsigned c = 0; c < CHANNELS; c++) out_data[c] <= acc_d[c][DW-1:0];
      end
      if (state_q == DIVIDE && (&div_done)) begin
        for (int unsigned c = 0; c < CHANNELS; c++) out_data[c] <= quot[c][DW-1:0];
      end
    end
  end

  // Dividers load the post-beat sum in the last-beat cycle, overlapping the
  // ACCUM->DIVIDE transition.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    pool_divider #(
      .ACC_W(ACC_W),
      .LEN_W(LEN_W)
    ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (acc_d[g]),
      .divisor  (len_q),
      .done     (div_done[g]),
      .quotient (quot[g])
    );
  end

endmodule

// File: tb/tb_pooling_unit.sv
module tb_pooling_unit;

  localparam int CH       = 4;
  localparam int DW       = 20;
  localparam int LEN_W    = 5;
  localparam int MEAN_LAT = 26;
  localparam int MAX_LAT  = 1;

  logic                 clk = 1'b0;
  logic                 rst, start, mode, in_valid, out_ready;
  logic                 in_ready, out_valid, busy;
  logic [LEN_W-1:0]     len_cfg;
  logic signed [DW-1:0] in_data  [CH];
  logic signed [DW-1:0] out_data [CH];
  logic [DW-1:0]        vec   [16][CH];
  logic [DW-1:0]        exp_v [CH];
  int                   n_tests = 0;
  int                   n_fail  = 0;

  always #5 clk = ~clk;

  pooling_unit #(
    .IL(4),
    .FL(16),
    .CHANNELS(CH),
    .MAX_LEN(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .len_cfg   (len_cfg),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [DW-1:0] a, b, c, d);
    vec[i][0] = a; vec[i][1] = b; vec[i][2] = c; vec[i][3] = d;
  endtask

  task automatic set_exp(input logic [DW-1:0] a, b, c, d);
    exp_v[0] = a; exp_v[1] = b; exp_v[2] = c; exp_v[3] = d;
  endtask

  task automatic do_start(input logic m, input logic [LEN_W-1:0] l);
    mode = m; len_cfg = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gaps != 0 inserts 1..3 idle cycles before odd beats, pulsing start there
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        int g_n = int'($urandom_range(1, 3));
        for (int g = 0; g < g_n; g++) begin
          in_valid = 1'b0; start = 1'b1; mode = 1'b1; len_cfg = 5'd1;
          tick();
          start = 1'b0;
        end
      end
      for (int c = 0; c < CH; c++) in_data[c] = vec[i][c];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 1;
    check($sformatf("%s_inready_drop", tag), {31'b0, in_ready}, 32'd0);
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check($sformatf("%s_latency", tag), lat, exp_lat);
  endtask

  task automatic check_out(input string tag);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_lane%0d", tag, c), {out_data[c]}, {exp_v[c]});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s_valid_clr", tag), {31'b0, out_valid}, 32'd0);
    check($sformatf("%s_idle", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; len_cfg = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < CH; c++) in_data[c] = '0;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    set_exp(20'h0, 20'h0, 20'h0, 20'h0);
    check_out("rst_data");
    rst = 1'b0;
    tick();

    // MEAN len 4
    set_vec(0, 20'h10000, 20'hF0000, 20'h00001, 20'hFFFFF);
    set_vec(1, 20'h20000, 20'hF0000, 20'h00002, 20'hFFFFF);
    set_vec(2, 20'h30000, 20'hF0000, 20'h00003, 20'hFFFFF);
    set_vec(3, 20'h40000, 20'hF0000, 20'hFFFFF, 20'hFFFFE);
    set_exp(20'h28000, 20'hF0000, 20'h00001, 20'hFFFFF);
    do_start(1'b0, 5'd4);
    check("mean_busy", {31'b0, busy}, 32'd1);
    check("mean_in_ready", {31'b0, in_ready}, 32'd1);
    feed(4, 1'b0);
    wait_out("mean", MEAN_LAT);
    check_out("mean");
    handshake("mean");

    // MAX len 3
    set_vec(0, 20'hE0000, 20'h80000, 20'h7FFFF, 20'hFFFFF);
    set_vec(1, 20'h08000, 20'h80000, 20'h00000, 20'hFFFFE);
    set_vec(2, 20'hFC000, 20'h80000, 20'h80000, 20'hFFFFD);
    set_exp(20'h08000, 20'h80000, 20'h7FFFF, 20'hFFFFF);
    do_start(1'b1, 5'd3);
    feed(3, 1'b0);
    wait_out("max", MAX_LAT);
    check_out("max");
    handshake("max");

    // MEAN truncation toward zero
    set_vec(0, 20'h00000, 20'h00001, 20'h00003, 20'hFFFFD);
    set_vec(1, 20'h00000, 20'h00001, 20'h00003, 20'hFFFFD);
    set_vec(2, 20'hFFFFF, 20'h00000, 20'h00003, 20'hFFFFC);
    set_exp(20'h00000, 20'h00000, 20'h00003, 20'hFFFFD);
    do_start(1'b0, 5'd3);
    feed(3, 1'b0);
    wait_out("trunc", MEAN_LAT + 0);
    check_out("trunc");
    handshake("trunc");

    // Handshake: input gaps, held output, stray starts
    set_vec(0, 20'h10000, 20'hF0000, 20'h00001, 20'hFFFFF);
    set_vec(1, 20'h20000, 20'hF0000, 20'h00002, 20'hFFFFF);
    set_vec(2, 20'h30000, 20'hF0000, 20'h00003, 20'hFFFFF);
    set_vec(3, 20'h40000, 20'hF0000, 20'hFFFFF, 20'hFFFFE);
    set_exp(20'h28000, 20'hF0000, 20'h00001, 20'hFFFFF);
    do_start(1'b0, 5'd4);
    feed(4, 1'b1);
    wait_out("hs", MEAN_LAT);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hs_hold_valid%0d", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("hs_hold_lane0_%0d", k), {out_data[0]}, 32'h28000);
      start = (k == 2); mode = 1'b1; len_cfg = 5'd0;
      tick();
      start = 1'b0;
    end
    check_out("hs");
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("hs_start_ignored", {31'b0, busy}, 32'd0);
    check("hs_valid_clr", {31'b0, out_valid}, 32'd0);
    check_out("hs_retain");

    // len_cfg = 0
    set_exp(20'h0, 20'h0, 20'h0, 20'h0);
    do_start(1'b0, 5'd0);
    check("len0_valid", {31'b0, out_valid}, 32'd1);
    check_out("len0");
    handshake("len0");

    // len_cfg above MAX_LEN clamps to 16
    for (int i = 0; i < 16; i++) set_vec(i, 20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h00001);
    set_exp(20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h00001);
    do_start(1'b0, 5'd31);
    feed(16, 1'b0);
    wait_out("clamp", MEAN_LAT);
    check_out("clamp");
    handshake("clamp");

    // Reset mid-ACCUM
    set_vec(0, 20'h70000, 20'h70000, 20'h70000, 20'h70000);
    set_vec(1, 20'h70000, 20'h70000, 20'h70000, 20'h70000);
    do_start(1'b0, 5'd4);
    feed(2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    set_exp(20'h0, 20'h0, 20'h0, 20'h0);
    check_out("midrst_data");
    set_vec(0, 20'h10000, 20'h10000, 20'hF0000, 20'h00004);
    set_vec(1, 20'h30000, 20'h10000, 20'hF0000, 20'h00000);
    set_exp(20'h20000, 20'h10000, 20'hF0000, 20'h00002);
    do_start(1'b0, 5'd2);
    feed(2, 1'b0);
    wait_out("fresh", MEAN_LAT);
    check_out("fresh");
    handshake("fresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
